// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared iterative multiply/divide unit: stalls the front of the
// pipeline, drives load/step enables for ITERS iterations, then presents the result.
module muldiv_sequencer #(
    parameter int ITERS = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             is_mult,
    input  logic             is_div,
    input  logic             operand_B_zero,
    input  logic [31:0]      ins_input,
    input  logic             flush,
    output logic             unit_load,
    output logic             unit_step,
    output logic             unit_mode,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic             exception,
    output logic [31:0]      ins_output,
    output logic [CNT_W-1:0] step_count
);

    // state | meaning
    // IDLE  | waiting for a mult/div request from decode
    // LOAD  | unit loads operands, step counter cleared
    // RUN   | unit iterates, one step per cycle
    // DONE  | result (or divide-by-zero) presented for one cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERS - 1);

    state_t state_q, state_d;
    logic   exc_q;
    logic   req;
    logic   div_zero;

    assign req      = (is_mult | is_div) & ~flush;
    assign div_zero = is_div & operand_B_zero & ~flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ins_output <= '0;
            step_count <= '0;
            unit_mode  <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        ins_output <= ins_input;
                        unit_mode  <= is_div;
                        exc_q      <= div_zero;
                    end
                end
                LOAD:    step_count <= '0;
                RUN:     step_count <= step_count + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // stall is combinational so the requesting cycle itself is already frozen
    always_comb begin
        state_d      = state_q;
        unit_load    = 1'b0;
        unit_step    = 1'b0;
        stall        = 1'b0;
        result_valid = 1'b0;
        exception    = 1'b0;
        busy         = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (req) begin
                    stall   = 1'b1;
                    state_d = div_zero ? DONE : LOAD;
                end
            end
            LOAD: begin
                unit_load = 1'b1;
                stall     = 1'b1;
                state_d   = flush ? IDLE : RUN;
            end
            RUN: begin
                unit_step = 1'b1;
                stall     = 1'b1;
                if (flush)
                    state_d = IDLE;
                else if (step_count == LAST_STEP)
                    state_d = DONE;
            end
            DONE: begin
                result_valid = ~flush;
                exception    = exc_q & ~flush;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed scenarios plus random traffic,
// compared every cycle against an operation-level timing model.
module tb_muldiv_sequencer;

    localparam int ITERS = 32;
    localparam int CNT_W = 6;

    logic             clock = 1'b0;
    logic             reset, is_mult, is_div, operand_B_zero, flush;
    logic [31:0]      ins_input;
    logic             unit_load, unit_step, unit_mode, stall, busy, result_valid, exception;
    logic [31:0]      ins_output;
    logic [CNT_W-1:0] step_count;

    muldiv_sequencer #(.ITERS(ITERS), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .is_mult(is_mult), .is_div(is_div),
        .operand_B_zero(operand_B_zero), .ins_input(ins_input), .flush(flush),
        .unit_load(unit_load), .unit_step(unit_step), .unit_mode(unit_mode),
        .stall(stall), .busy(busy), .result_valid(result_valid), .exception(exception),
        .ins_output(ins_output), .step_count(step_count)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int n      = 0;
    int loads_seen = 0;
    int steps_seen = 0;

    // Model: an op accepted at cycle t0 has LOAD at t0+1, steps at t0+2..t0+ITERS+1,
    // result at t0+ITERS+2; a divide-by-zero presents its result at t0+1.
    bit          m_active = 0;
    bit          m_dbz    = 0;
    int          m_t0     = 0;
    int          m_sc     = 0;
    logic        m_mode   = 0;
    logic [31:0] m_ins    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, n, obs, exp);
    endtask

    task automatic check_outputs();
        logic e_load, e_step, e_rv, e_exc, e_stall, e_busy, req;
        int   e_sc, d;
        req = (is_mult | is_div) & ~flush;
        d = n - m_t0;
        e_load = 0; e_step = 0; e_rv = 0; e_exc = 0; e_stall = 0; e_busy = 0;
        e_sc = m_sc;
        if (!m_active) begin
            e_stall = req;
        end else if (m_dbz) begin
            e_busy = 1; e_rv = ~flush; e_exc = ~flush;
        end else begin
            e_busy  = 1;
            e_load  = (d == 1);
            e_step  = (d >= 2) && (d <= ITERS + 1);
            e_stall = (d <= ITERS + 1);
            e_rv    = (d == ITERS + 2) && !flush;
            if (e_step) e_sc = d - 2;
            else if (d == ITERS + 2) e_sc = ITERS;
        end
        chk("unit_load",    32'(unit_load),    32'(e_load));
        chk("unit_step",    32'(unit_step),    32'(e_step));
        chk("stall",        32'(stall),        32'(e_stall));
        chk("busy",         32'(busy),         32'(e_busy));
        chk("result_valid", 32'(result_valid), 32'(e_rv));
        if (result_valid) chk("exception", 32'(exception), 32'(e_exc));
        else              chk("exception_idle", 32'(exception), 32'(0));
        chk("unit_mode",    32'(unit_mode),    32'(m_mode));
        chk("ins_output",   ins_output,        m_ins);
        chk("step_count",   32'(step_count),   32'(e_sc));
    endtask

    task automatic model_update();
        int d;
        d = n - m_t0;
        if (reset) begin
            m_active = 0; m_sc = 0; m_ins = 0; m_mode = 0;
        end else if (!m_active) begin
            if ((is_mult | is_div) & ~flush) begin
                m_active = 1; m_t0 = n;
                m_dbz  = is_div & operand_B_zero;
                m_mode = is_div;
                m_ins  = ins_input;
            end
        end else if (m_dbz) begin
            m_active = 0;
        end else begin
            if (d == 1) m_sc = 0;
            else if (d <= ITERS + 1) m_sc = d - 1;
            if (flush || d == ITERS + 2) m_active = 0;
        end
        n++;
    endtask

    task automatic cyc(input logic m, input logic dv, input logic z, input logic f,
                       input logic r, input logic [31:0] w);
        is_mult = m; is_div = dv; operand_B_zero = z; flush = f; reset = r; ins_input = w;
        @(negedge clock);
        if (!r) begin
            check_outputs();
            if (unit_load) loads_seen++;
            if (unit_step) steps_seen++;
        end
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        is_mult = 0; is_div = 0; operand_B_zero = 0; flush = 0; reset = 1; ins_input = 0;
        @(posedge clock); #1;
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle(3);

        // multiply, full latency
        loads_seen = 0; steps_seen = 0;
        cyc(1, 0, 0, 0, 0, 32'h00A3_1234);
        idle(36);
        chk("mult_loads", 32'(loads_seen), 32'(1));
        chk("mult_steps", 32'(steps_seen), 32'(ITERS));

        // divide by zero short-circuit
        loads_seen = 0; steps_seen = 0;
        cyc(0, 1, 1, 0, 0, 32'hDEAD_0001);
        idle(4);
        chk("dbz_loads", 32'(loads_seen), 32'(0));
        chk("dbz_steps", 32'(steps_seen), 32'(0));

        // flush in RUN when step_count = 5
        cyc(0, 1, 0, 0, 0, 32'h1234_5678);
        idle(6);
        chk("pre_flush_count", 32'(step_count), 32'(5));
        cyc(0, 0, 0, 1, 0, 32'h0);
        idle(40);

        // request held through DONE: second op starts at cycle 35
        loads_seen = 0;
        for (int i = 0; i < 40; i++) cyc(1, 0, 0, 0, 0, 32'hCAFE_0000 + 32'(i));
        idle(36);
        chk("held_req_loads", 32'(loads_seen), 32'(2));

        // mult and div together: divide mode, same timing
        cyc(1, 1, 0, 0, 0, 32'h0BAD_F00D);
        idle(36);

        // reset mid-RUN at step_count = 10
        cyc(1, 0, 0, 0, 0, 32'h5555_AAAA);
        idle(11);
        chk("pre_reset_count", 32'(step_count), 32'(10));
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle(3);

        // random traffic, including noise while busy and occasional flushes
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
                $urandom_range(29) == 0, $urandom_range(499) == 0, $urandom);
        idle(40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
